cfd_verilog_driver: RTL and testbench

//  Synthesizable stimulus sequencer for the 16-channel CFD front-end chip model.

---
 rtl/cfd_verilog_driver.sv | 248 ++++++++++++++++++++++++
 tb/tb_cfd_verilog_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cfd_verilog_driver.sv
// Stimulus sequencer for the 16-channel CFD front-end model: it powers up the chip,
// resets it, writes one mode word per channel, then fires a train of per-channel pulses.
module cfd_verilog_driver #(
    parameter int unsigned NEG       = 1,
    parameter int unsigned CHANNELS  = 16,
    parameter int unsigned DATABITS  = 8,
    parameter int unsigned ADDRBITS  = 4,
    parameter int unsigned MODEBITS  = 4,
    parameter int unsigned VW        = 12,
    parameter int unsigned AVDD_MV   = 1800,
    parameter int unsigned DVDD_MV   = 1800,
    parameter int unsigned AVSS_MV   = 0,
    parameter int unsigned VMID_MV   = 900,
    parameter logic [3:0]  MODE      = 4'h3,
    parameter int unsigned PWR_CYC   = 64,
    parameter int unsigned RST_CYC   = 16,
    parameter int unsigned TRIG_DLY  = 4,
    parameter int unsigned RISE_CYC  = 8,
    parameter int unsigned RISE_STEP = 100,
    parameter int unsigned PULSE_PER = 64,
    parameter int unsigned NPULSES   = 32,
    parameter int unsigned AMP0      = 100,
    parameter int unsigned AMP_STEP  = 20
) (
    input  logic                   clk,
    input  logic                   rst_in_l,
    output logic [VW-1:0]          avdd,
    output logic [VW-1:0]          avss,
    output logic [VW-1:0]          dvdd,
    output logic [VW-1:0]          dgnd,
    output logic                   rst_l,
    output logic                   neg_pol,
    output logic                   agnd_int_disable,
    output logic [DATABITS-1:0]    data,
    output logic                   stb,
    output logic [CHANNELS*VW-1:0] peak,
    output logic [CHANNELS-1:0]    trig,
    output logic                   gen,
    output logic [VW-1:0]          rise,
    output logic                   done
);

    localparam int unsigned CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned MAXV  = (1 << VW) - 1;
    localparam logic [VW-1:0] AVDD_C = VW'(AVDD_MV);
    localparam logic [VW-1:0] DVDD_C = VW'(DVDD_MV);
    localparam logic [VW-1:0] AVSS_C = VW'(AVSS_MV);
    localparam logic [VW-1:0] VMID_C = VW'(VMID_MV);
    localparam logic [VW-1:0] STEP_C = (RISE_STEP > MAXV) ? VW'(MAXV) : VW'(RISE_STEP);
    localparam logic [MODEBITS-1:0] MODE_C = MODEBITS'(MODE);
    localparam logic NEG_BIT = (NEG != 0);

    typedef enum logic [2:0] {S_PWR, S_CHIPRST, S_CFG, S_PULSE, S_IDLE} state_t;

    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [ADDRBITS-1:0] addr_reg, addr_next;
    logic [1:0]          phase_reg, phase_next;
    logic [15:0]         k_reg, k_next;
    logic [CHW-1:0]      ch_reg, ch_next;

    logic [VW-1:0]       avdd_next, avss_next, dvdd_next, rise_next;
    logic                rst_l_next, stb_next, gen_next, done_next;
    logic [DATABITS-1:0] data_next;
    logic [CHANNELS-1:0] trig_next;
    logic                pulse_load, peak_clear;

    logic [VW:0]         rise_sum;
    logic [VW-1:0]       rise_sat;
    logic [31:0]         amp_w;
    logic [VW-1:0]       peak_val;

    assign rise_sum = {1'b0, rise} + {1'b0, STEP_C};
    assign rise_sat = rise_sum[VW] ? {VW{1'b1}} : rise_sum[VW-1:0];

    // Pulse amplitude around the mid-rail baseline, clamped to the code range.
    always_comb begin
        amp_w = AMP0 + 32'(k_reg) * AMP_STEP;
        if (NEG_BIT)
            peak_val = (amp_w >= VMID_MV) ? '0 : VW'(VMID_MV - amp_w);
        else
            peak_val = (VMID_MV + amp_w > MAXV) ? VW'(MAXV) : VW'(VMID_MV + amp_w);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        phase_next = phase_reg;
        k_next     = k_reg;
        ch_next    = ch_reg;
        avdd_next  = avdd;
        avss_next  = avss;
        dvdd_next  = dvdd;
        rst_l_next = rst_l;
        data_next  = data;
        stb_next   = 1'b0;
        gen_next   = 1'b0;
        trig_next  = '0;
        rise_next  = rise;
        done_next  = done;
        pulse_load = 1'b0;
        peak_clear = 1'b0;
        case (state_reg)
            S_PWR: begin
                avdd_next  = AVDD_C;
                dvdd_next  = DVDD_C;
                avss_next  = AVSS_C;
                rst_l_next = 1'b0;
                if (cnt_reg == 16'(PWR_CYC - 1)) begin
                    cnt_next   = '0;
                    state_next = S_CHIPRST;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_CHIPRST: begin
                rst_l_next = 1'b0;
                if (cnt_reg == 16'(RST_CYC - 1)) begin
                    rst_l_next = 1'b1;
                    cnt_next   = '0;
                    addr_next  = '0;
                    phase_next = 2'd0;
                    state_next = S_CFG;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_CFG: begin
                rst_l_next = 1'b1;
                case (phase_reg)
                    2'd0: begin
                        data_next  = DATABITS'({addr_reg, MODE_C});
                        phase_next = 2'd1;
                    end
                    2'd1: begin
                        stb_next   = 1'b1;
                        phase_next = 2'd2;
                    end
                    default: begin
                        phase_next = 2'd0;
                        if (addr_reg == ADDRBITS'(CHANNELS - 1)) begin
                            cnt_next   = '0;
                            k_next     = '0;
                            ch_next    = '0;
                            state_next = S_PULSE;
                        end else begin
                            addr_next = addr_reg + ADDRBITS'(1);
                        end
                    end
                endcase
            end
            S_PULSE: begin
                rst_l_next = 1'b1;
                data_next  = '0;
                if (cnt_reg == 16'd0) begin
                    gen_next   = 1'b1;
                    pulse_load = 1'b1;
                    rise_next  = STEP_C;
                end else if (cnt_reg < 16'(RISE_CYC)) begin
                    rise_next = rise_sat;
                end else begin
                    rise_next = '0;
                end
                if (cnt_reg == 16'(TRIG_DLY))
                    trig_next = CHANNELS'(1) << ch_reg;
                if (cnt_reg == 16'(PULSE_PER - 1)) begin
                    cnt_next = '0;
                    if (k_reg == 16'(NPULSES - 1)) begin
                        state_next = S_IDLE;
                    end else begin
                        k_next  = k_reg + 16'd1;
                        ch_next = (ch_reg == CHW'(CHANNELS - 1)) ? '0 : ch_reg + CHW'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_IDLE: begin
                rst_l_next = 1'b1;
                data_next  = '0;
                rise_next  = '0;
                done_next  = 1'b1;
                peak_clear = 1'b1;
            end
            default: state_next = S_PWR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in_l) begin
        if (!rst_in_l) begin
            state_reg        <= S_PWR;
            cnt_reg          <= '0;
            addr_reg         <= '0;
            phase_reg        <= '0;
            k_reg            <= '0;
            ch_reg           <= '0;
            avdd             <= '0;
            avss             <= '0;
            dvdd             <= '0;
            dgnd             <= '0;
            rst_l            <= 1'b0;
            neg_pol          <= NEG_BIT;
            agnd_int_disable <= 1'b0;
            data             <= '0;
            stb              <= 1'b0;
            trig             <= '0;
            gen              <= 1'b0;
            rise             <= '0;
            done             <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            addr_reg         <= addr_next;
            phase_reg        <= phase_next;
            k_reg            <= k_next;
            ch_reg           <= ch_next;
            avdd             <= avdd_next;
            avss             <= avss_next;
            dvdd             <= dvdd_next;
            dgnd             <= '0;
            rst_l            <= rst_l_next;
            neg_pol          <= NEG_BIT;
            agnd_int_disable <= 1'b0;
            data             <= data_next;
            stb              <= stb_next;
            trig             <= trig_next;
            gen              <= gen_next;
            rise             <= rise_next;
            done             <= done_next;
        end
    end

    // One register per lane: the firing lane loads the pulse, the rest fall back to baseline.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic [VW-1:0] lane_reg;
        always_ff @(posedge clk or negedge rst_in_l) begin
            if (!rst_in_l)
                lane_reg <= VMID_C;
            else if (pulse_load)
                lane_reg <= (ch_reg == CHW'(gi)) ? peak_val : VMID_C;
            else if (peak_clear)
                lane_reg <= VMID_C;
        end
        assign peak[gi*VW +: VW] = lane_reg;
    end

endmodule

// File: tb/tb_cfd_verilog_driver.sv
// Directed bench for cfd_verilog_driver: a negative- and a positive-polarity instance run
// side by side; expected strobes, pulses and triggers are queued up front and popped as seen.
module tb_cfd_verilog_driver;

    localparam int VW = 12;
    localparam int CH = 16;

    logic clk = 1'b0;
    logic rst_in_l = 1'b0;
    always #5 clk = ~clk;

    logic [VW-1:0] avdd0, avss0, dvdd0, dgnd0, rise0;
    logic [VW-1:0] avdd1, avss1, dvdd1, dgnd1, rise1;
    logic rst_l0, neg_pol0, agnd0, stb0, gen0, done0;
    logic rst_l1, neg_pol1, agnd1, stb1, gen1, done1;
    logic [7:0] data0, data1;
    logic [CH*VW-1:0] peak0, peak1;
    logic [CH-1:0] trig0, trig1;

    cfd_verilog_driver #(.NEG(1)) u0 (
        .clk(clk), .rst_in_l(rst_in_l),
        .avdd(avdd0), .avss(avss0), .dvdd(dvdd0), .dgnd(dgnd0),
        .rst_l(rst_l0), .neg_pol(neg_pol0), .agnd_int_disable(agnd0),
        .data(data0), .stb(stb0), .peak(peak0), .trig(trig0),
        .gen(gen0), .rise(rise0), .done(done0)
    );

    cfd_verilog_driver #(.NEG(0)) u1 (
        .clk(clk), .rst_in_l(rst_in_l),
        .avdd(avdd1), .avss(avss1), .dvdd(dvdd1), .dgnd(dgnd1),
        .rst_l(rst_l1), .neg_pol(neg_pol1), .agnd_int_disable(agnd1),
        .data(data1), .stb(stb1), .peak(peak1), .trig(trig1),
        .gen(gen1), .rise(rise1), .done(done1)
    );

    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int cyc; int ch; int v0; int v1; } pulse_t;

    ev_t    cfg_q[$];
    ev_t    trig_q[$];
    pulse_t gen_q[$];

    int vec  = 0;
    int miss = 0;
    int n    = 0;
    logic rst_prev, stb_prev;
    logic [7:0] data_prev, data_at_stb;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH*VW-1:0] peak_vec(input int ch, input int val);
        logic [CH*VW-1:0] v;
        for (int i = 0; i < CH; i++)
            v[i*VW +: VW] = (i == ch) ? VW'(val) : VW'(900);
        return v;
    endfunction

    task automatic fill_queues();
        for (int a = 0; a < 16; a++)
            cfg_q.push_back(ev_t'{82 + 3*a, a*16 + 3});
        for (int k = 0; k < 32; k++) begin
            gen_q.push_back(pulse_t'{129 + 64*k, k % 16, 900 - (100 + 20*k), 900 + (100 + 20*k)});
            trig_q.push_back(ev_t'{133 + 64*k, 1 << (k % 16)});
        end
    endtask

    task automatic check_reset_state();
        chk("rst_avdd", avdd0, 0);
        chk("rst_dvdd", dvdd0, 0);
        chk("rst_rst_l", rst_l0, 0);
        chk("rst_stb", stb0, 0);
        chk("rst_data", data0, 0);
        chk("rst_gen", gen0, 0);
        chk("rst_trig", trig0, 0);
        chk("rst_rise", rise0, 0);
        chk("rst_done", done0, 0);
        chk("rst_peak0", peak0, peak_vec(-1, 0));
        chk("rst_peak1", peak1, peak_vec(-1, 0));
    endtask

    task automatic release_reset();
        rst_in_l = 1'b1;
        n = 0;
        rst_prev = 1'b0;
        stb_prev = 1'b0;
        data_prev = 8'h00;
        fill_queues();
        #1;
        chk("avdd_first_cycle", avdd0, 0);
        @(negedge clk);
        n = 1;
        chk("avdd_on", avdd0, 1800);
        chk("dvdd_on", dvdd0, 1800);
        chk("avss_on", avss0, 0);
        chk("rst_l_low", rst_l0, 0);
    endtask

    task automatic check_cycle();
        ev_t e;
        pulse_t p;
        if (rst_l0 && !rst_prev)
            chk("rst_l_rise_cycle", n, 80);
        if (stb_prev)
            chk("data_hold", data0, data_at_stb);
        if (stb0) begin
            chk("stb_gen_overlap", gen0, 0);
            chk("data_setup", data0, data_prev);
            if (cfg_q.size() == 0) begin
                chk("stb_extra", 1, 0);
            end else begin
                e = cfg_q.pop_front();
                chk("stb_cycle", n, e.cyc);
                chk("stb_data", data0, e.val);
            end
            data_at_stb = data0;
        end
        if (gen0) begin
            if (gen_q.size() == 0) begin
                chk("gen_extra", 1, 0);
            end else begin
                p = gen_q.pop_front();
                chk("gen_cycle", n, p.cyc);
                chk("gen_pos_inst", gen1, 1);
                chk("peak_neg", peak0, peak_vec(p.ch, p.v0));
                chk("peak_pos", peak1, peak_vec(p.ch, p.v1));
                chk("done_early", done0, 0);
            end
        end
        if (gen0 || gen1)
            chk("gen_pair", {gen0, gen1}, 2'b11);
        if (trig0 != 0 || trig1 != 0) begin
            if (trig_q.size() == 0) begin
                chk("trig_extra", 1, 0);
            end else begin
                e = trig_q.pop_front();
                chk("trig_cycle", n, e.cyc);
                chk("trig_neg", trig0, e.val);
                chk("trig_pos", trig1, e.val);
            end
        end
        if (n >= 129 && n <= 137)
            chk("rise_pulse0", rise0, (n < 137) ? (n - 128) * 100 : 0);
        rst_prev  = rst_l0;
        stb_prev  = stb0;
        data_prev = data0;
    endtask

    task automatic run_to(input int last);
        while (n < last) begin
            @(negedge clk);
            n++;
            check_cycle();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state();
        chk("neg_pol_neg", neg_pol0, 1);
        chk("neg_pol_pos", neg_pol1, 0);
        chk("agnd_dis", agnd0, 0);

        // Pass 1: whole sequence through to IDLE.
        release_reset();
        run_to(2180);
        chk("done_idle", done0, 1);
        chk("done_idle_pos", done1, 1);
        chk("idle_peak", peak0, peak_vec(-1, 0));
        chk("idle_rise", rise0, 0);
        chk("idle_rst_l", rst_l0, 1);
        chk("idle_avdd", avdd0, 1800);
        chk("cfg_q_empty", cfg_q.size(), 0);
        chk("gen_q_empty", gen_q.size(), 0);
        chk("trig_q_empty", trig_q.size(), 0);

        // Pass 2: reset in the middle of pulse 1, then restart.
        rst_in_l = 1'b0;
        @(negedge clk);
        cfg_q.delete(); gen_q.delete(); trig_q.delete();
        release_reset();
        run_to(200);
        chk("mid_pulse_rise", rise0, 800);
        #2 rst_in_l = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        cfg_q.delete(); gen_q.delete(); trig_q.delete();
        release_reset();
        run_to(130);
        chk("restart_cfg_done", cfg_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
